// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction memory request/response bus between fetch unit and imem
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: credit-limited imem requests, in-order fetch queue, redirect with stale drop
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        pause_ifu,
  input  logic        branch_ifu_taken,
  input  logic [63:0] branch_ifu_pc,
  ifu_fetch_if.master imem,
  output logic        ifu_dfu_valid,
  output logic [63:0] ifu_dfu_pc,
  output logic [31:0] ifu_dfu_inst,
  output logic        ifu_err
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e        state_q;
  logic [63:0]   fetch_pc_q, rsp_pc_q;
  logic [CW-1:0] outstanding_q, count_q, drop_cnt_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [63:0]   fq_pc_q   [FQ_DEPTH];
  logic [31:0]   fq_inst_q [FQ_DEPTH];
  logic          dfu_valid_q, err_q;
  logic [63:0]   dfu_pc_q;
  logic [31:0]   dfu_inst_q;

  logic          pop, credit, req_valid, req_fire, rsp_ok, push, spurious;
  logic [CW:0]   occupancy;
  logic [CW-1:0] outstanding_d, count_d, drop_cnt_d;
  logic [PW-1:0] rd_ptr_d, wr_ptr_d;
  logic [63:0]   redirect_pc, head_pc;
  logic [31:0]   head_inst;

  assign redirect_pc = branch_ifu_pc & ~64'h3;

  always_comb begin
    pop        = dfu_valid_q & ~pause_ifu & ~branch_ifu_taken;
    // Buffered entries plus in-flight requests must never exceed the queue size.
    occupancy  = {1'b0, outstanding_q} + {1'b0, count_q} - (CW+1)'(pop);
    credit     = occupancy < DEPTH_C;
    req_valid  = (state_q == FETCH) & credit & ~branch_ifu_taken;
    req_fire   = req_valid & imem.imem_req_ready;
    spurious   = imem.imem_rsp_valid & (outstanding_q == '0);
    rsp_ok     = imem.imem_rsp_valid & (outstanding_q != '0);
    push       = rsp_ok & (drop_cnt_q == '0) & ~branch_ifu_taken;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    if (branch_ifu_taken) begin
      drop_cnt_d = outstanding_q - CW'(rsp_ok);
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
    end else begin
      drop_cnt_d = drop_cnt_q - CW'(rsp_ok & (drop_cnt_q != '0));
      count_d    = count_q + CW'(push) - CW'(pop);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
    end
    // Next head may be the entry being written this cycle.
    head_pc   = fq_pc_q[rd_ptr_d];
    head_inst = fq_inst_q[rd_ptr_d];
    if (push && (rd_ptr_d == wr_ptr_q)) begin
      head_pc   = rsp_pc_q;
      head_inst = imem.imem_rsp_data;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc_q;

  always_ff @(posedge core_clk) begin
    if (push) begin
      fq_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fq_inst_q[wr_ptr_q] <= imem.imem_rsp_data;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      dfu_valid_q   <= 1'b0;
      dfu_pc_q      <= '0;
      dfu_inst_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (branch_ifu_taken && (drop_cnt_d != '0)) state_q <= DRAIN;
        DRAIN:   if (drop_cnt_d == '0) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (branch_ifu_taken) begin
        fetch_pc_q <= redirect_pc;
        rsp_pc_q   <= redirect_pc;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + 64'd4;
        if (push)     rsp_pc_q   <= rsp_pc_q + 64'd4;
      end
      if (count_d != '0) begin
        dfu_valid_q <= 1'b1;
        dfu_pc_q    <= head_pc;
        dfu_inst_q  <= head_inst;
      end else begin
        dfu_valid_q <= 1'b0;
      end
      if (spurious) err_q <= 1'b1;
    end
  end

  assign ifu_dfu_valid = dfu_valid_q;
  assign ifu_dfu_pc    = dfu_pc_q;
  assign ifu_dfu_inst  = dfu_inst_q;
  assign ifu_err       = err_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with a 1-cycle in-order memory model
module tb_ifu_fetch;
  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b1;
  logic        pause_ifu, branch_ifu_taken;
  logic [63:0] branch_ifu_pc;
  logic        ifu_dfu_valid, ifu_err;
  logic [63:0] ifu_dfu_pc;
  logic [31:0] ifu_dfu_inst;

  ifu_fetch_if imem();

  ifu_fetch dut (
    .core_clk         (core_clk),
    .core_rst_n       (core_rst_n),
    .pause_ifu        (pause_ifu),
    .branch_ifu_taken (branch_ifu_taken),
    .branch_ifu_pc    (branch_ifu_pc),
    .imem             (imem),
    .ifu_dfu_valid    (ifu_dfu_valid),
    .ifu_dfu_pc       (ifu_dfu_pc),
    .ifu_dfu_inst     (ifu_dfu_inst),
    .ifu_err          (ifu_err)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic        pause;
    logic        ready;
    logic        rv;
    logic [63:0] addr;
    logic        dv;
    logic [63:0] pc;
  } vec_t;

  vec_t        tbl [28];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] pend [$];
  bit          mem_hold = 1'b0;

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    logic        acc;
    logic [63:0] acc_addr;
    #1;
    acc      = imem.imem_req_valid & imem.imem_req_ready;
    acc_addr = imem.imem_req_addr;
    @(posedge core_clk);
    if (acc) pend.push_back(acc_addr);
    @(negedge core_clk);
    if (!mem_hold && pend.size() > 0) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = inst_of(pend.pop_front());
    end else begin
      imem.imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    core_rst_n          = 1'b0;
    pend.delete();
    imem.imem_rsp_valid = 1'b0;
    repeat (2) @(negedge core_clk);
    core_rst_n          = 1'b1;
  endtask

  initial begin
    int          n;
    bit          seen_req;
    logic        sv_dv;
    logic [63:0] sv_pc;
    logic [31:0] sv_inst;

    // pause, ready | req_valid, req_addr, dfu_valid, dfu_pc
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 64'h8000_0000, 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0004};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0014, 1'b1, 64'h8000_0008};
    for (int i = 7; i < 15; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 64'h8000_0018, 1'b1, 64'h8000_0008};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_0008};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 64'h8000_001C, 1'b1, 64'h8000_000C};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 64'h8000_0020, 1'b1, 64'h8000_0010};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 64'h8000_0024, 1'b1, 64'h8000_0014};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 64'h8000_0028, 1'b1, 64'h8000_0018};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 64'h8000_002C, 1'b1, 64'h8000_001C};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 64'h8000_002C, 1'b1, 64'h8000_0020};
    tbl[22] = '{1'b0, 1'b0, 1'b1, 64'h8000_002C, 1'b1, 64'h8000_0024};
    tbl[23] = '{1'b0, 1'b0, 1'b1, 64'h8000_002C, 1'b1, 64'h8000_0028};
    tbl[24] = '{1'b0, 1'b0, 1'b1, 64'h8000_002C, 1'b0, 64'h8000_0028};
    tbl[25] = '{1'b0, 1'b1, 1'b1, 64'h8000_002C, 1'b0, 64'h8000_0028};
    tbl[26] = '{1'b0, 1'b1, 1'b1, 64'h8000_0030, 1'b0, 64'h8000_0028};
    tbl[27] = '{1'b0, 1'b1, 1'b1, 64'h8000_0034, 1'b1, 64'h8000_002C};

    pause_ifu           = 1'b0;
    branch_ifu_taken    = 1'b0;
    branch_ifu_pc       = '0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;

    #1 core_rst_n = 1'b0;
    #1;
    chk("rst_dv",   {63'b0, ifu_dfu_valid}, 64'h0);
    chk("rst_pc",   ifu_dfu_pc, 64'h0);
    chk("rst_inst", {32'b0, ifu_dfu_inst}, 64'h0);
    chk("rst_rv",   {63'b0, imem.imem_req_valid}, 64'h0);
    chk("rst_err",  {63'b0, ifu_err}, 64'h0);
    do_reset();

    for (int i = 0; i < 28; i++) begin
      pause_ifu           = tbl[i].pause;
      imem.imem_req_ready = tbl[i].ready;
      #1;
      chk($sformatf("c%0d rv", i + 1),   {63'b0, imem.imem_req_valid}, {63'b0, tbl[i].rv});
      chk($sformatf("c%0d addr", i + 1), imem.imem_req_addr, tbl[i].addr);
      chk($sformatf("c%0d dv", i + 1),   {63'b0, ifu_dfu_valid}, {63'b0, tbl[i].dv});
      chk($sformatf("c%0d pc", i + 1),   ifu_dfu_pc, tbl[i].pc);
      chk($sformatf("c%0d inst", i + 1), {32'b0, ifu_dfu_inst},
          {32'b0, (tbl[i].pc == 64'h0) ? 32'h0 : inst_of(tbl[i].pc)});
      cyc();
    end

    // Redirect with three requests in flight, responses held back.
    do_reset();
    mem_hold = 1'b1;
    repeat (4) cyc();
    branch_ifu_taken = 1'b1;
    branch_ifu_pc    = 64'h8000_1002;
    #1;
    chk("redir_noreq", {63'b0, imem.imem_req_valid}, 64'h0);
    cyc();
    branch_ifu_taken = 1'b0;
    mem_hold         = 1'b0;
    #1;
    chk("drain_noreq", {63'b0, imem.imem_req_valid}, 64'h0);
    chk("drain_addr",  imem.imem_req_addr, 64'h8000_1000);
    n = 0;
    seen_req = 1'b0;
    while (!ifu_dfu_valid && n < 20) begin
      if (imem.imem_req_valid && !seen_req) begin
        seen_req = 1'b1;
        chk("redir_addr", imem.imem_req_addr, 64'h8000_1000);
      end
      cyc();
      #1;
      n++;
    end
    chk("redir_req_seen", {63'b0, seen_req}, 64'h1);
    chk("redir_head_dv",  {63'b0, ifu_dfu_valid}, 64'h1);
    chk("redir_head_pc",  ifu_dfu_pc, 64'h8000_1000);
    chk("redir_head_inst", {32'b0, ifu_dfu_inst}, {32'b0, inst_of(64'h8000_1000)});
    cyc();
    #1;
    chk("redir_next_pc", ifu_dfu_pc, 64'h8000_1004);

    // Spurious response with nothing outstanding.
    pause_ifu           = 1'b1;
    imem.imem_req_ready = 1'b0;
    repeat (4) cyc();
    #1;
    chk("err_clear", {63'b0, ifu_err}, 64'h0);
    sv_dv   = ifu_dfu_valid;
    sv_pc   = ifu_dfu_pc;
    sv_inst = ifu_dfu_inst;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    #1;
    chk("spur_err",  {63'b0, ifu_err}, 64'h1);
    chk("spur_dv",   {63'b0, ifu_dfu_valid}, {63'b0, sv_dv});
    chk("spur_pc",   ifu_dfu_pc, sv_pc);
    chk("spur_inst", {32'b0, ifu_dfu_inst}, {32'b0, sv_inst});
    pause_ifu           = 1'b0;
    imem.imem_req_ready = 1'b1;
    repeat (6) cyc();
    #1;
    chk("err_sticky", {63'b0, ifu_err}, 64'h1);

    // Reset asserted while draining stale responses.
    mem_hold = 1'b1;
    repeat (3) cyc();
    branch_ifu_taken = 1'b1;
    branch_ifu_pc    = 64'h8000_2000;
    cyc();
    branch_ifu_taken = 1'b0;
    #1;
    chk("drain2_noreq", {63'b0, imem.imem_req_valid}, 64'h0);
    chk("drain2_addr",  imem.imem_req_addr, 64'h8000_2000);
    #1 core_rst_n = 1'b0;
    pend.delete();
    imem.imem_rsp_valid = 1'b0;
    mem_hold = 1'b0;
    #1;
    chk("mrst_dv",   {63'b0, ifu_dfu_valid}, 64'h0);
    chk("mrst_pc",   ifu_dfu_pc, 64'h0);
    chk("mrst_inst", {32'b0, ifu_dfu_inst}, 64'h0);
    chk("mrst_rv",   {63'b0, imem.imem_req_valid}, 64'h0);
    chk("mrst_err",  {63'b0, ifu_err}, 64'h0);
    @(negedge core_clk);
    @(negedge core_clk);
    core_rst_n = 1'b1;
    #1;
    chk("restart_idle_rv", {63'b0, imem.imem_req_valid}, 64'h0);
    cyc();
    #1;
    chk("restart_rv",   {63'b0, imem.imem_req_valid}, 64'h1);
    chk("restart_addr", imem.imem_req_addr, 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
